// File: rtl/rover_pkg.sv
// Shared rover definitions: H-bridge direction words, controller state
// encoding and IPS sensor bit positions, plus the sensor decode helpers.
package rover_pkg;

  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b1001;
  localparam logic [3:0] DIR_LEFT  = 4'b1010;
  localparam logic [3:0] DIR_RIGHT = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FOLLOW   = 3'd1,
    ST_SEARCH_L = 3'd2,
    ST_SEARCH_R = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  localparam int IPS_LEFT  = 2;
  localparam int IPS_MID   = 1;
  localparam int IPS_RIGHT = 0;

  // Sensors are active-low: a 0 bit means the sensor sees the line.
  function automatic logic any_lit(input logic [2:0] s);
    return s != 3'b111;
  endfunction

  function automatic logic [3:0] decode_ips(input logic [2:0] s);
    if (!s[IPS_MID])        return DIR_FWD;
    else if (!s[IPS_LEFT])  return DIR_LEFT;
    else if (!s[IPS_RIGHT]) return DIR_RIGHT;
    else                    return DIR_STOP;
  endfunction

endpackage

// File: rtl/hbridge_deadtime.sv
// H-bridge output stage: registers the direction word, inserts STOP dead-time
// whenever the bridge would reverse, and gates the PWM pulse onto the enables.
module hbridge_deadtime
  import rover_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_on,
  input  logic       speed,
  input  logic [3:0] cmd,
  output logic [3:0] in,
  output logic [1:0] en
);

  logic [3:0]  in_q, in_d;
  logic        dead_q, dead_d;
  logic [31:0] dead_cnt_q, dead_cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    in_d       = in_q;
    dead_d     = dead_q;
    dead_cnt_d = dead_cnt_q;
    if (!sw_on) begin
      in_d       = DIR_STOP;
      dead_d     = 1'b0;
      dead_cnt_d = '0;
    end else if (dead_q) begin
      // Load whatever command is current at expiry; changes meanwhile do not restart the count.
      if (dead_cnt_q == DEAD_CYCLES - 1) begin
        in_d       = cmd;
        dead_d     = 1'b0;
        dead_cnt_d = '0;
      end else begin
        dead_cnt_d = dead_cnt_q + 32'd1;
      end
    end else if (cmd == DIR_STOP || cmd == in_q || in_q == DIR_STOP) begin
      in_d = cmd;
    end else begin
      in_d       = DIR_STOP;
      dead_d     = 1'b1;
      dead_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q       <= DIR_STOP;
      dead_q     <= 1'b0;
      dead_cnt_q <= '0;
    end else begin
      in_q       <= in_d;
      dead_q     <= dead_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign in = in_q;
  // speed is gated combinationally so the PWM edge sees no added latency.
  assign en = (sw_on && !dead_q && in_q != DIR_STOP) ? {2{speed}} : 2'b00;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follow sequencer: synchronises the IPS sensors, runs the
// follow / search-left / search-right / halt machine and drives the H-bridge stage.
module line_follow_ctrl
  import rover_pkg::*;
#(
  parameter int unsigned LOSS_CYCLES  = 1_000_000,
  parameter int unsigned LEFT_CYCLES  = 200_000_000,
  parameter int unsigned RIGHT_CYCLES = 400_000_000,
  parameter int unsigned DEAD_CYCLES  = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ips,
  input  logic       speed,
  input  logic       sw_on,
  output logic [3:0] in,
  output logic [1:0] en,
  output logic [2:0] state
);

  logic [2:0]  sync1_q, s_q;
  logic        sw_q;
  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [3:0]  last_cmd_q, last_cmd_d;
  logic [31:0] loss_cnt_q, loss_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic        lit;
  logic [3:0]  word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b111;
      s_q     <= 3'b111;
      sw_q    <= 1'b0;
    end else begin
      sync1_q <= ips;
      s_q     <= sync1_q;
      sw_q    <= sw_on;
    end
  end

  assign lit  = any_lit(s_q);
  assign word = decode_ips(s_q);

  // The command is computed for the state being entered, so cmd_q always
  // matches state_q after the same edge.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    last_cmd_d = last_cmd_q;
    loss_cnt_d = loss_cnt_q;
    timer_d    = timer_q;
    if (!sw_on) begin
      state_d    = ST_IDLE;
      cmd_d      = DIR_STOP;
      last_cmd_d = DIR_FWD;
      loss_cnt_d = '0;
      timer_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_d = DIR_STOP;
          if (sw_q) begin
            state_d = ST_FOLLOW;
            cmd_d   = lit ? word : last_cmd_q;
          end
        end
        ST_FOLLOW: begin
          if (lit) begin
            cmd_d      = word;
            last_cmd_d = word;
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LOSS_CYCLES - 1) begin
            state_d    = ST_SEARCH_L;
            cmd_d      = DIR_LEFT;
            loss_cnt_d = '0;
            timer_d    = '0;
          end else begin
            cmd_d      = last_cmd_q;
            loss_cnt_d = loss_cnt_q + 32'd1;
          end
        end
        ST_SEARCH_L: begin
          // A sensor lighting on the expiry cycle wins over the timer.
          if (lit) begin
            state_d    = ST_FOLLOW;
            cmd_d      = word;
            last_cmd_d = word;
            timer_d    = '0;
          end else if (timer_q == LEFT_CYCLES - 1) begin
            state_d = ST_SEARCH_R;
            cmd_d   = DIR_RIGHT;
            timer_d = '0;
          end else begin
            cmd_d   = DIR_LEFT;
            timer_d = timer_q + 32'd1;
          end
        end
        ST_SEARCH_R: begin
          if (lit) begin
            state_d    = ST_FOLLOW;
            cmd_d      = word;
            last_cmd_d = word;
            timer_d    = '0;
          end else if (timer_q == RIGHT_CYCLES - 1) begin
            state_d = ST_HALT;
            cmd_d   = DIR_STOP;
            timer_d = '0;
          end else begin
            cmd_d   = DIR_RIGHT;
            timer_d = timer_q + 32'd1;
          end
        end
        ST_HALT: begin
          cmd_d = DIR_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          cmd_d   = DIR_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= DIR_STOP;
      last_cmd_q <= DIR_FWD;
      loss_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      last_cmd_q <= last_cmd_d;
      loss_cnt_q <= loss_cnt_d;
      timer_q    <= timer_d;
    end
  end

  assign state = state_q;

  hbridge_deadtime #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_hbridge (
    .clk   (clk),
    .rst   (rst),
    .sw_on (sw_on),
    .speed (speed),
    .cmd   (cmd_q),
    .in    (in),
    .en    (en)
  );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with shortened timing parameters:
// start-up, loss/search/halt sequence, timer-vs-sensor race, reversal dead-time, async reset.
module tb_line_follow_ctrl;
  import rover_pkg::*;

  localparam int unsigned LOSS  = 4;
  localparam int unsigned LEFT  = 8;
  localparam int unsigned RIGHT = 16;
  localparam int unsigned DEAD  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ips;
  logic       speed;
  logic       sw_on;
  logic [3:0] in_w;
  logic [1:0] en;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_follow_ctrl #(
    .LOSS_CYCLES  (LOSS),
    .LEFT_CYCLES  (LEFT),
    .RIGHT_CYCLES (RIGHT),
    .DEAD_CYCLES  (DEAD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ips   (ips),
    .speed (speed),
    .sw_on (sw_on),
    .in    (in_w),
    .en    (en),
    .state (state)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_on = 1'b0; ips = 3'b111; speed = 1'b1;
    #2;
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL reset_in: got %b expected %b", in_w, DIR_STOP); end
    n_vec++; if (en !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b expected 00", en); end
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_hold_state: got %0d expected 0", state); end
  endtask

  task automatic test_start();
    sw_on = 1'b1; ips = 3'b101;
    tick();
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL start_edge1_state: got %0d expected 0", state); end
    tick();
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL start_edge2_state: got %0d expected 1", state); end
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL start_edge2_in: got %b expected %b", in_w, DIR_STOP); end
    tick();
    n_vec++; if (in_w !== DIR_FWD) begin n_err++; $display("FAIL start_fwd_in: got %b expected %b", in_w, DIR_FWD); end
    n_vec++; if (en !== 2'b11) begin n_err++; $display("FAIL start_en_hi: got %b expected 11", en); end
    speed = 1'b0; #1;
    n_vec++; if (en !== 2'b00) begin n_err++; $display("FAIL start_en_lo: got %b expected 00", en); end
    speed = 1'b1; #1;
    n_vec++; if (en !== 2'b11) begin n_err++; $display("FAIL start_en_hi2: got %b expected 11", en); end
  endtask

  task automatic test_loss_search();
    logic [3:0] exp_in;
    ips = 3'b111;
    // Two sync edges plus LOSS dark cycles in FOLLOW holding FWD.
    for (int i = 0; i <= int'(LOSS); i++) begin
      tick();
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL loss_state[%0d]: got %0d expected 1", i, state); end
      n_vec++; if (in_w !== DIR_FWD) begin n_err++; $display("FAIL loss_in[%0d]: got %b expected %b", i, in_w, DIR_FWD); end
    end
    tick();
    n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL searchl_entry_state: got %0d expected 2", state); end
    for (int t = 1; t < int'(LEFT); t++) begin
      tick();
      exp_in = (t <= int'(DEAD)) ? DIR_STOP : DIR_LEFT;
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL searchl_state[%0d]: got %0d expected 2", t, state); end
      n_vec++; if (in_w !== exp_in) begin n_err++; $display("FAIL searchl_in[%0d]: got %b expected %b", t, in_w, exp_in); end
      n_vec++; if (en !== ((exp_in == DIR_STOP) ? 2'b00 : 2'b11)) begin n_err++; $display("FAIL searchl_en[%0d]: got %b", t, en); end
    end
    tick();
    n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL searchr_entry_state: got %0d expected 3", state); end
    for (int t = 1; t < int'(RIGHT); t++) begin
      tick();
      exp_in = (t <= int'(DEAD)) ? DIR_STOP : DIR_RIGHT;
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL searchr_state[%0d]: got %0d expected 3", t, state); end
      n_vec++; if (in_w !== exp_in) begin n_err++; $display("FAIL searchr_in[%0d]: got %b expected %b", t, in_w, exp_in); end
      n_vec++; if (en !== ((exp_in == DIR_STOP) ? 2'b00 : 2'b11)) begin n_err++; $display("FAIL searchr_en[%0d]: got %b", t, en); end
    end
    tick();
    n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL halt_state: got %0d expected 4", state); end
    tick();
    n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL halt_hold_state: got %0d expected 4", state); end
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL halt_in: got %b expected %b", in_w, DIR_STOP); end
    n_vec++; if (en !== 2'b00) begin n_err++; $display("FAIL halt_en: got %b expected 00", en); end
  endtask

  task automatic test_halt_switch_off();
    sw_on = 1'b0;
    tick();
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL swoff_state: got %0d expected 0", state); end
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL swoff_in: got %b expected %b", in_w, DIR_STOP); end
  endtask

  task automatic test_same_cycle();
    sw_on = 1'b1; ips = 3'b111;
    tick(); tick();
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL race_follow_state: got %0d expected 1", state); end
    repeat (LOSS) tick();
    n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL race_searchl_state: got %0d expected 2", state); end
    // Time the sensor so it reaches s on the cycle timer == LEFT-1.
    repeat (LEFT - 3) tick();
    ips = 3'b011;
    tick();
    n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL race_pre1_state: got %0d expected 2", state); end
    tick();
    n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL race_pre2_state: got %0d expected 2", state); end
    n_vec++; if (in_w !== DIR_LEFT) begin n_err++; $display("FAIL race_pre2_in: got %b expected %b", in_w, DIR_LEFT); end
    tick();
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL race_follow_win: got %0d expected 1", state); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL race_stay_state[%0d]: got %0d expected 1", i, state); end
      n_vec++; if (in_w !== DIR_LEFT) begin n_err++; $display("FAIL race_stay_in[%0d]: got %b expected %b", i, in_w, DIR_LEFT); end
    end
  endtask

  task automatic test_reverse();
    ips = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (in_w !== DIR_LEFT) begin n_err++; $display("FAIL rev_pre_in[%0d]: got %b expected %b", i, in_w, DIR_LEFT); end
    end
    for (int i = 0; i < int'(DEAD); i++) begin
      tick();
      n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL rev_dead_in[%0d]: got %b expected %b", i, in_w, DIR_STOP); end
      n_vec++; if (en !== 2'b00) begin n_err++; $display("FAIL rev_dead_en[%0d]: got %b expected 00", i, en); end
    end
    tick();
    n_vec++; if (in_w !== DIR_RIGHT) begin n_err++; $display("FAIL rev_post_in: got %b expected %b", in_w, DIR_RIGHT); end
    n_vec++; if (en !== 2'b11) begin n_err++; $display("FAIL rev_post_en: got %b expected 11", en); end
  endtask

  task automatic test_async_reset();
    // Mid dead-time: reverse right -> left, then reset between edges.
    ips = 3'b011;
    repeat (4) tick();
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL ar_dead_in: got %b expected %b", in_w, DIR_STOP); end
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL ar_dead_state: got %0d expected 1", state); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL ar_dead_rst_state: got %0d expected 0", state); end
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL ar_dead_rst_in: got %b expected %b", in_w, DIR_STOP); end
    tick();
    rst = 1'b0; ips = 3'b111;
    // Restart and run into SEARCH_L with LEFT on the bridge.
    tick(); tick();
    repeat (LOSS) tick();
    n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL ar_search_state: got %0d expected 2", state); end
    repeat (5) tick();
    n_vec++; if (in_w !== DIR_LEFT) begin n_err++; $display("FAIL ar_search_in: got %b expected %b", in_w, DIR_LEFT); end
    n_vec++; if (en !== 2'b11) begin n_err++; $display("FAIL ar_search_en: got %b expected 11", en); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL ar_search_rst_state: got %0d expected 0", state); end
    n_vec++; if (in_w !== DIR_STOP) begin n_err++; $display("FAIL ar_search_rst_in: got %b expected %b", in_w, DIR_STOP); end
    n_vec++; if (en !== 2'b00) begin n_err++; $display("FAIL ar_search_rst_en: got %b expected 00", en); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_loss_search();
    test_halt_switch_off();
    test_same_cycle();
    test_reverse();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
